// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and FWFT mode
module sync_fifo_flex #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     err_clr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     write_en,
  input  logic                     read_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_do_wr;
  logic w_do_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Flush discards any request issued in the same cycle.
  assign w_do_wr = write_en && !w_full  && !flush;
  assign w_do_rd = read_en  && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr && !rst) r_mem[r_wr_ptr] <= data_in;
  end

  // A new error in the same cycle as err_clr wins; flushed requests raise nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !err_clr) || (write_en && w_full  && !flush);
      r_udf <= (r_udf && !err_clr) || (read_en  && w_empty && !flush);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst)          r_dout <= '0;
        else if (w_do_rd) r_dout <= r_mem[r_rd_ptr];
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench for sync_fifo_flex in registered and FWFT modes
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, err_clr, wr, rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, af, ae, ovf, udf;
  logic [4:0] cnt;

  logic       b_flush, b_err_clr, b_wr, b_rd;
  logic [7:0] b_din;
  logic [7:0] b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] b_cnt;

  sync_fifo_flex #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .data_in(din),
    .write_en(wr), .read_en(rd), .data_out(dout), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .count(cnt), .overflow(ovf), .underflow(udf)
  );

  sync_fifo_flex #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .flush(b_flush), .err_clr(b_err_clr), .data_in(b_din),
    .write_en(b_wr), .read_en(b_rd), .data_out(b_dout), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       rd_issued = 1'b0;
  logic       rd_tag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read data monitor: one word expected the cycle after each accepted read.
  always @(posedge clk) rd_tag <= rd_issued;

  always @(negedge clk) begin
    if (rd_tag) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_data: got %0h expected none", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_errors++;
          $display("FAIL rd_data: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  task automatic check_state(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " count"}, 32'(cnt), 32'(sz));
    chk({tag, " full"},  32'(full),  32'(sz == 16));
    chk({tag, " empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, " af"},    32'(af),    32'(sz >= 14));
    chk({tag, " ae"},    32'(ae),    32'(sz <= 2));
    chk({tag, " ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, " udf"},   32'(udf),   32'(m_udf));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic fl, input logic ec);
    int   sz;
    logic wacc, racc;
    sz   = mq.size();
    wr = w; rd = r; din = d; flush = fl; err_clr = ec;
    wacc = w && (sz < 16) && !fl;
    racc = r && (sz > 0) && !fl;
    if (fl) begin
      m_ovf = m_ovf && !ec;
      m_udf = m_udf && !ec;
    end else begin
      m_ovf = (m_ovf && !ec) || (w && sz == 16);
      m_udf = (m_udf && !ec) || (r && sz == 0);
    end
    rd_issued = racc;
    if (racc) exp_q.push_back(mq[0]);
    if (fl) mq.delete();
    else begin
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0; rd_issued = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1; wr = w; din = 8'hEE; rd_issued = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic bstep(input logic w, input logic r, input logic [7:0] d, input logic fl);
    b_wr = w; b_rd = r; b_din = d; b_flush = fl;
    @(posedge clk);
    @(negedge clk);
    b_wr = 1'b0; b_rd = 1'b0; b_flush = 1'b0;
  endtask

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    b_flush = 1'b0; b_err_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = 8'h00;
    @(negedge clk);
    do_reset(1'b0);
    check_state("reset");
    chk("reset dout", 32'(dout), 32'h0);

    // Fill 0x01..0x10 then drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      check_state("fill");
    end
    chk("full after 16", 32'(full), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check_state("drain");
    end
    chk("drain last dout", 32'(dout), 32'h10);

    // Full with both requested: read wins, 0xAA dropped
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    check_state("ovf");
    chk("ovf count", 32'(cnt), 32'd15);
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_state("ovf drain");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_state("err_clr");

    // Empty with both requested: write wins, data_out holds
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    check_state("udf");
    chk("udf count", 32'(cnt), 32'd1);
    chk("udf dout hold", 32'(dout), 32'h10);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_state("udf clr");

    // Steady state at count 8 across pointer wraps
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      chk("steady count", 32'(cnt), 32'd8);
    end
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_state("steady drain");

    // Flush at count 10 with overflow set
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pre-flush count", 32'(cnt), 32'd10);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    check_state("flush");
    chk("flush ovf kept", 32'(ovf), 32'h1);
    chk("flush dout hold", 32'(dout), 32'h06);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush err_clr", 32'(ovf), 32'h0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    do_reset(1'b1);
    check_state("mid reset");
    chk("mid reset dout", 32'(dout), 32'h0);
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_state("post reset");

    // FWFT instance
    chk("fwft reset dout", 32'(b_dout), 32'h0);
    chk("fwft reset empty", 32'(b_empty), 32'h1);
    bstep(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("fwft first word", 32'(b_dout), 32'h3C);
    chk("fwft not empty", 32'(b_empty), 32'h0);
    bstep(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft read zero", 32'(b_dout), 32'h0);
    chk("fwft empty again", 32'(b_empty), 32'h1);
    bstep(1'b1, 1'b0, 8'h11, 1'b0);
    bstep(1'b1, 1'b0, 8'h22, 1'b0);
    chk("fwft head", 32'(b_dout), 32'h11);
    bstep(1'b1, 1'b1, 8'h33, 1'b0);
    chk("fwft next", 32'(b_dout), 32'h22);
    chk("fwft count", 32'(b_cnt), 32'd2);
    bstep(1'b1, 1'b0, 8'h44, 1'b1);
    chk("fwft flush dout", 32'(b_dout), 32'h0);
    chk("fwft flush count", 32'(b_cnt), 32'd0);
    chk("fwft flush empty", 32'(b_empty), 32'h1);

    @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
